// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial input, frame configuration and the received-byte outputs.
// Frame-format encoding matches the transmitter so one configuration drives both ends.
interface uart_rx_if;
   logic       i_rx;
   logic       i_exist_oddcheck;
   logic       i_exist_evencheck;
   logic       i_exist_stop;
   logic [3:0] i_bitnum;
   logic [7:0] o_data;
   logic       o_data_valid;
   logic       o_parity_err;
   logic       o_frame_err;
   logic       o_busy;

   modport slave (
      input  i_rx, i_exist_oddcheck, i_exist_evencheck, i_exist_stop, i_bitnum,
      output o_data, o_data_valid, o_parity_err, o_frame_err, o_busy
   );

   modport master (
      output i_rx, i_exist_oddcheck, i_exist_evencheck, i_exist_stop, i_bitnum,
      input  o_data, o_data_valid, o_parity_err, o_frame_err, o_busy
   );
endinterface

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver: start, 5-8 data bits LSB first, optional parity and stop.
// Each bit is sampled at cnt = 7; the frame completes one cycle after its final sample.
module uart_rx #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input logic     i_clkx16,
   input logic     i_rst,
   uart_rx_if.slave bus
);

   typedef enum logic [2:0] {StIdle, StStart, StRxData, StCheck, StStop} state_e;

   state_e                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   dly_q;
   logic                   synced;
   logic [3:0]             cnt_q, cnt_d;
   logic [2:0]             bit_idx_q, bit_idx_d;
   logic [2:0]             last_idx_q, last_idx_d;
   logic                   par_en_q, par_en_d;
   logic                   par_odd_q, par_odd_d;
   logic                   stop_en_q, stop_en_d;
   logic [7:0]             shift_q, shift_d;
   logic                   par_acc_q, par_acc_d;
   logic                   perr_q, perr_d;
   logic [7:0]             data_q, data_d;
   logic                   valid_q, valid_d;
   logic                   perr_out_q, perr_out_d;
   logic                   ferr_out_q, ferr_out_d;
   logic                   mid, bnd, done, stop_bad;
   logic [2:0]             last_idx_cfg;

   assign synced = sync_q[SYNC_STAGES-1];
   assign mid    = (cnt_q == 4'd7);
   assign bnd    = (cnt_q == 4'd15);

   // Clamp data-bit count to 5..8 and store it as the index of the last data bit.
   always_comb begin
      if (bus.i_bitnum < 4'd5) begin
         last_idx_cfg = 3'd4;
      end else if (bus.i_bitnum > 4'd8) begin
         last_idx_cfg = 3'd7;
      end else begin
         last_idx_cfg = 3'(bus.i_bitnum - 4'd1);
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = (state_q == StIdle) ? 4'd0 : cnt_q + 4'd1;
      bit_idx_d  = bit_idx_q;
      last_idx_d = last_idx_q;
      par_en_d   = par_en_q;
      par_odd_d  = par_odd_q;
      stop_en_d  = stop_en_q;
      shift_d    = shift_q;
      par_acc_d  = par_acc_q;
      perr_d     = perr_q;
      data_d     = data_q;
      valid_d    = 1'b0;
      perr_out_d = perr_out_q;
      ferr_out_d = ferr_out_q;
      done       = 1'b0;
      stop_bad   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (dly_q && !synced) begin
               state_d    = StStart;
               last_idx_d = last_idx_cfg;
               par_en_d   = bus.i_exist_oddcheck | bus.i_exist_evencheck;
               par_odd_d  = bus.i_exist_oddcheck;
               stop_en_d  = bus.i_exist_stop;
               bit_idx_d  = 3'd0;
               shift_d    = 8'h00;
               par_acc_d  = 1'b0;
               perr_d     = 1'b0;
            end
         end
         StStart: begin
            if (mid && synced) begin
               state_d = StIdle;
            end else if (bnd) begin
               state_d = StRxData;
            end
         end
         StRxData: begin
            if (mid) begin
               shift_d[bit_idx_q] = synced;
               par_acc_d          = par_acc_q ^ synced;
               bit_idx_d          = bit_idx_q + 3'd1;
               if (bit_idx_q == last_idx_q && !par_en_q && !stop_en_q) begin
                  done = 1'b1;
               end
            end
            // bit_idx has moved one past the last index once the final bit is in.
            if (bnd && bit_idx_q == last_idx_q + 3'd1) begin
               state_d = par_en_q ? StCheck : StStop;
            end
         end
         StCheck: begin
            if (mid) begin
               perr_d = par_odd_q ? ~(par_acc_q ^ synced) : (par_acc_q ^ synced);
               done   = !stop_en_q;
            end
            if (bnd) begin
               state_d = StStop;
            end
         end
         StStop: begin
            if (mid) begin
               stop_bad = ~synced;
               done     = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      if (done) begin
         state_d    = StIdle;
         valid_d    = 1'b1;
         data_d     = shift_d;
         perr_out_d = par_en_q & perr_d;
         ferr_out_d = stop_en_q & stop_bad;
      end
   end

   always_ff @(posedge i_clkx16 or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= StIdle;
         sync_q     <= '1;
         dly_q      <= 1'b1;
         cnt_q      <= 4'd0;
         bit_idx_q  <= 3'd0;
         last_idx_q <= 3'd7;
         par_en_q   <= 1'b0;
         par_odd_q  <= 1'b0;
         stop_en_q  <= 1'b0;
         shift_q    <= 8'h00;
         par_acc_q  <= 1'b0;
         perr_q     <= 1'b0;
         data_q     <= 8'h00;
         valid_q    <= 1'b0;
         perr_out_q <= 1'b0;
         ferr_out_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         sync_q     <= {sync_q[SYNC_STAGES-2:0], bus.i_rx};
         dly_q      <= synced;
         cnt_q      <= cnt_d;
         bit_idx_q  <= bit_idx_d;
         last_idx_q <= last_idx_d;
         par_en_q   <= par_en_d;
         par_odd_q  <= par_odd_d;
         stop_en_q  <= stop_en_d;
         shift_q    <= shift_d;
         par_acc_q  <= par_acc_d;
         perr_q     <= perr_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         perr_out_q <= perr_out_d;
         ferr_out_q <= ferr_out_d;
      end
   end

   assign bus.o_data       = data_q;
   assign bus.o_data_valid = valid_q;
   assign bus.o_parity_err = perr_out_q;
   assign bus.o_frame_err  = ferr_out_q;
   assign bus.o_busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: fixed vector table, hand-built corner sequences and random frames
// checked against a frame-level model of what the line carried.
module tb_uart_rx;
   localparam int S = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   uart_rx_if bus();

   uart_rx #(.SYNC_STAGES(S)) dut (
      .i_clkx16 (clk),
      .i_rst    (rst),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] d;
      logic       pe;
      logic       fe;
   } rx_t;

   typedef struct {
      logic [3:0] bn;
      logic       odd;
      logic       even;
      logic       stop;
      logic [7:0] d;
      logic       flip;
      logic       slow;
      int         gap;
      logic [7:0] ed;
      logic       epe;
      logic       efe;
   } vec_t;

   rx_t  rxq[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   drv_cyc = 0;
   int   rise_cyc = 0;
   int   busy_fall_cyc = 0;
   int   valid_cyc = 0;
   logic busy_prev = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.o_data_valid) begin
         rxq.push_back('{d: bus.o_data, pe: bus.o_parity_err, fe: bus.o_frame_err});
         valid_cyc <= cyc;
      end
      if (bus.o_busy && !busy_prev) rise_cyc <= cyc;
      if (!bus.o_busy && busy_prev) busy_fall_cyc <= cyc;
      busy_prev <= bus.o_busy;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drive one frame; the model returns what a correct receiver must report for it.
   task automatic send_frame(input logic [3:0] bn, input logic odd, input logic even,
                             input logic stop, input logic [7:0] d, input logic flip,
                             input logic slow, input int gap, output logic [7:0] ed,
                             output logic epe, output logic efe);
      int   nb;
      int   ones;
      logic pen;
      logic pbit;
      nb   = (bn < 5) ? 5 : ((bn > 8) ? 8 : int'(bn));
      ed   = 8'((32'd1 << nb) - 1) & d;
      pen  = odd | even;
      pbit = (odd ? ~(^ed) : (^ed)) ^ flip;
      ones = $countones(ed) + ((pen && pbit) ? 1 : 0);
      epe  = pen && (odd ? (ones % 2 == 0) : (ones % 2 == 1));
      efe  = stop && slow;

      bus.i_bitnum          = bn;
      bus.i_exist_oddcheck  = odd;
      bus.i_exist_evencheck = even;
      bus.i_exist_stop      = stop;
      drv_cyc               = cyc;
      bus.i_rx              = 1'b0;
      tick(16);
      // Scramble configuration mid-frame; the receiver must keep its latched copy.
      bus.i_bitnum          = 4'($urandom);
      bus.i_exist_oddcheck  = 1'($urandom);
      bus.i_exist_evencheck = 1'($urandom);
      bus.i_exist_stop      = 1'($urandom);
      for (int i = 0; i < nb; i++) begin
         bus.i_rx = d[i];
         tick(16);
      end
      if (pen) begin
         bus.i_rx = pbit;
         tick(16);
      end
      if (stop) begin
         bus.i_rx = ~slow;
         tick(16);
      end
      bus.i_rx = 1'b1;
      tick(gap);
   endtask

   task automatic expect_one(input string tag, input logic [7:0] ed, input logic epe,
                             input logic efe);
      rx_t r;
      check({tag, "_pulses"}, rxq.size(), 1);
      if (rxq.size() > 0) begin
         r = rxq.pop_front();
         check({tag, "_data"}, r.d, ed);
         check({tag, "_perr"}, r.pe, epe);
         check({tag, "_ferr"}, r.fe, efe);
      end
      rxq.delete();
   endtask

   initial begin
      vec_t       vecs[13];
      logic [7:0] ed;
      logic       epe;
      logic       efe;
      int         lat;

      vecs[0]  = '{4'd8,  1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 16, 8'hA5, 1'b0, 1'b0};
      vecs[1]  = '{4'd7,  1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 16, 8'h5A, 1'b0, 1'b0};
      vecs[2]  = '{4'd7,  1'b0, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 16, 8'h5A, 1'b1, 1'b0};
      vecs[3]  = '{4'd8,  1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 16, 8'h00, 1'b0, 1'b1};
      vecs[4]  = '{4'd8,  1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 16, 8'h3C, 1'b0, 1'b0};
      vecs[5]  = '{4'd5,  1'b0, 1'b0, 1'b0, 8'h13, 1'b0, 1'b0, 2,  8'h13, 1'b0, 1'b0};
      vecs[6]  = '{4'd5,  1'b0, 1'b0, 1'b0, 8'h0C, 1'b0, 1'b0, 2,  8'h0C, 1'b0, 1'b0};
      vecs[7]  = '{4'd8,  1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 0,  8'h00, 1'b0, 1'b0};
      vecs[8]  = '{4'd8,  1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 16, 8'hFF, 1'b0, 1'b0};
      vecs[9]  = '{4'd3,  1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 16, 8'h1F, 1'b0, 1'b0};
      vecs[10] = '{4'd12, 1'b0, 1'b0, 1'b1, 8'h81, 1'b0, 1'b0, 16, 8'h81, 1'b0, 1'b0};
      vecs[11] = '{4'd8,  1'b1, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 16, 8'h01, 1'b0, 1'b0};
      vecs[12] = '{4'd6,  1'b1, 1'b0, 1'b0, 8'h2A, 1'b1, 1'b0, 16, 8'h2A, 1'b1, 1'b0};

      bus.i_rx              = 1'b1;
      bus.i_bitnum          = 4'd8;
      bus.i_exist_oddcheck  = 1'b0;
      bus.i_exist_evencheck = 1'b0;
      bus.i_exist_stop      = 1'b1;
      rst                   = 1'b1;
      tick(5);
      check("rst_data", bus.o_data, 0);
      check("rst_valid", bus.o_data_valid, 0);
      check("rst_perr", bus.o_parity_err, 0);
      check("rst_ferr", bus.o_frame_err, 0);
      check("rst_busy", bus.o_busy, 0);
      rst = 1'b0;
      tick(20);

      // 8N1 timing: busy spans D+1..D+152, valid lands at D+153.
      send_frame(4'd8, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 16, ed, epe, efe);
      expect_one("timing_a5", 8'hA5, 1'b0, 1'b0);
      lat = rise_cyc - drv_cyc;
      check("detect_latency_in_window", int'(lat == S + 1 || lat == S + 2), 1);
      check("valid_after_busy_rise", valid_cyc - rise_cyc, 152);
      check("busy_span", busy_fall_cyc - rise_cyc, 152);

      for (int i = 0; i < 13; i++) begin
         send_frame(vecs[i].bn, vecs[i].odd, vecs[i].even, vecs[i].stop, vecs[i].d,
                    vecs[i].flip, vecs[i].slow, vecs[i].gap, ed, epe, efe);
         expect_one($sformatf("vec%0d", i), vecs[i].ed, vecs[i].epe, vecs[i].efe);
      end

      // Glitch: 4 low clocks in idle must be rejected at the start-bit mid sample.
      drv_cyc  = cyc;
      bus.i_rx = 1'b0;
      tick(4);
      bus.i_rx = 1'b1;
      tick(40);
      check("glitch_pulses", rxq.size(), 0);
      check("glitch_busy_seen", int'(rise_cyc > drv_cyc), 1);
      check("glitch_busy_span", busy_fall_cyc - rise_cyc, 8);
      check("glitch_busy_after", bus.o_busy, 0);
      rxq.delete();

      // Reset during data bits: no pulse, then a clean frame.
      bus.i_bitnum          = 4'd8;
      bus.i_exist_oddcheck  = 1'b0;
      bus.i_exist_evencheck = 1'b0;
      bus.i_exist_stop      = 1'b1;
      bus.i_rx              = 1'b0;
      tick(16);
      bus.i_rx = 1'b1;
      tick(16);
      bus.i_rx = 1'b0;
      tick(10);
      check("midframe_busy", bus.o_busy, 1);
      rst = 1'b1;
      tick(2);
      check("midreset_busy", bus.o_busy, 0);
      check("midreset_data", bus.o_data, 0);
      bus.i_rx = 1'b1;
      rst      = 1'b0;
      tick(40);
      check("midreset_pulses", rxq.size(), 0);
      rxq.delete();
      send_frame(4'd8, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 16, ed, epe, efe);
      expect_one("after_reset", 8'h3C, 1'b0, 1'b0);

      // No stop bit and the line held low afterwards: exactly one frame.
      bus.i_bitnum          = 4'd5;
      bus.i_exist_oddcheck  = 1'b0;
      bus.i_exist_evencheck = 1'b0;
      bus.i_exist_stop      = 1'b0;
      bus.i_rx              = 1'b0;
      tick(16 * 6 + 200);
      check("held_low_busy", bus.o_busy, 0);
      expect_one("held_low", 8'h00, 1'b0, 1'b0);
      bus.i_rx = 1'b1;
      tick(20);

      for (int i = 0; i < 30; i++) begin
         logic [3:0] bn;
         logic       odd, even, stop, flip, slow;
         logic [7:0] d;
         int         gap;
         bn   = 4'($urandom_range(0, 15));
         odd  = 1'($urandom);
         even = 1'($urandom);
         stop = 1'($urandom);
         flip = 1'($urandom);
         slow = stop & ($urandom_range(0, 3) == 0);
         d    = 8'($urandom);
         gap  = (stop && !slow) ? int'($urandom_range(0, 20)) : int'($urandom_range(2, 20));
         send_frame(bn, odd, even, stop, d, flip, slow, gap, ed, epe, efe);
         expect_one($sformatf("rand%0d", i), ed, epe, efe);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
